// File: rtl/neosd_card_cmd.sv
// SD card-side CMD line engine: receives 48-bit host commands and returns R1/R3/R2 responses.
// Optional NEOSD_CARD_CRC_CHECK_EN enables CRC7 checking of received commands.
module neosd_card_cmd #(
    parameter int NCR_CYCLES = 2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         sd_clk_i,
    input  logic         sd_cmd_i,
    output logic         sd_cmd_o,
    output logic         sd_cmd_oe,
    output logic         cmd_valid_o,
    output logic [5:0]   cmd_idx_o,
    output logic [31:0]  cmd_arg_o,
    input  logic         resp_valid_i,
    input  logic [1:0]   resp_type_i,
    input  logic [127:0] resp_dat_i,
    output logic         resp_ready_o,
    output logic         busy_o,
    output logic         frm_err_o,
    output logic         crc_err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RX, S_CHECK, S_WAIT_RESP, S_NCR, S_TX, S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic          sd_clk_q;
    logic [7:0]    cnt_q, cnt_d, cnt_inc;
    logic [46:0]   rx_q, rx_d;
    logic [135:0]  tx_q, tx_d;
    logic          tx_long_q, tx_long_d;
    logic          cmd_o_q, cmd_o_d, cmd_oe_q, cmd_oe_d;
    logic          valid_q, valid_d, frm_q, frm_d, crc_q, crc_d;
    logic [5:0]    idx_q, idx_d;
    logic [31:0]   arg_q, arg_d;
    logic          rise, fall, frm_ok, crc_ok;
    logic [39:0]   rsp_pre;
    logic [47:0]   rsp_short;
    logic [135:0]  rsp_long;
    logic          dat_unused;

    // Leading zeros leave a zero-initialised CRC untouched, so shorter messages are left-padded.
    function automatic logic [6:0] crc7(input logic [119:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 119; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign rise    = sd_clk_i & ~sd_clk_q;
    assign fall    = ~sd_clk_i & sd_clk_q;
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // rx_q holds frame bits [46:0]; the start bit is implied zero.
    assign frm_ok = rx_q[46] & rx_q[0];
`ifdef NEOSD_CARD_CRC_CHECK_EN
    assign crc_ok = (crc7({80'b0, 1'b0, rx_q[46:8]}) == rx_q[7:1]);
`else
    logic crc_unused;
    assign crc_unused = ^rx_q[7:1];
    assign crc_ok     = 1'b1;
`endif

    assign rsp_pre    = {2'b00, resp_dat_i[37:0]};
    assign rsp_short  = {rsp_pre, (resp_type_i == 2'd1) ? 7'h7F : crc7({80'b0, rsp_pre}), 1'b1};
    assign rsp_long   = {8'h3F, resp_dat_i[127:8], crc7(resp_dat_i[127:8]), 1'b1};
    assign dat_unused = ^resp_dat_i[7:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        tx_long_d = tx_long_q;
        cmd_o_d   = cmd_o_q;
        cmd_oe_d  = cmd_oe_q;
        valid_d   = 1'b0;
        frm_d     = 1'b0;
        crc_d     = 1'b0;
        idx_d     = idx_q;
        arg_d     = arg_q;
        case (state_q)
            S_IDLE: if (rise && !sd_cmd_i) begin
                state_d = S_RX;
                cnt_d   = 8'd1;
                rx_d    = '0;
            end
            S_RX: if (rise) begin
                rx_d  = {rx_q[45:0], sd_cmd_i};
                cnt_d = cnt_inc;
                if (cnt_q == 8'd47) state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (!frm_ok) begin
                    frm_d = 1'b1;
                end else if (!crc_ok) begin
                    crc_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    idx_d   = rx_q[45:40];
                    arg_d   = rx_q[39:8];
                    state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: if (resp_valid_i) begin
                if (resp_type_i == 2'd3) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_NCR;
                    cnt_d     = '0;
                    tx_long_d = (resp_type_i == 2'd2);
                    tx_d      = (resp_type_i == 2'd2) ? rsp_long : {rsp_short, 88'b0};
                end
            end
            S_NCR: if (fall) begin
                if (cnt_q == 8'(NCR_CYCLES)) begin
                    state_d  = S_TX;
                    cmd_oe_d = 1'b1;
                    cmd_o_d  = tx_q[135];
                    tx_d     = {tx_q[134:0], 1'b0};
                    cnt_d    = 8'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_TX: if (fall) begin
                cmd_o_d = tx_q[135];
                tx_d    = {tx_q[134:0], 1'b0};
                cnt_d   = cnt_inc;
                // The end bit goes out now and is held one full period inside RELEASE.
                if (cnt_q == (tx_long_q ? 8'd135 : 8'd47)) state_d = S_RELEASE;
            end
            S_RELEASE: if (fall) begin
                cmd_oe_d = 1'b0;
                cmd_o_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            sd_clk_q  <= 1'b0;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            tx_long_q <= 1'b0;
            cmd_o_q   <= 1'b1;
            cmd_oe_q  <= 1'b0;
            valid_q   <= 1'b0;
            frm_q     <= 1'b0;
            crc_q     <= 1'b0;
            idx_q     <= '0;
            arg_q     <= '0;
        end else begin
            state_q   <= state_d;
            sd_clk_q  <= sd_clk_i;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            tx_long_q <= tx_long_d;
            cmd_o_q   <= cmd_o_d;
            cmd_oe_q  <= cmd_oe_d;
            valid_q   <= valid_d;
            frm_q     <= frm_d;
            crc_q     <= crc_d;
            idx_q     <= idx_d;
            arg_q     <= arg_d;
        end
    end

    assign sd_cmd_o     = cmd_o_q;
    assign sd_cmd_oe    = cmd_oe_q;
    assign cmd_valid_o  = valid_q;
    assign cmd_idx_o    = idx_q;
    assign cmd_arg_o    = arg_q;
    assign frm_err_o    = frm_q;
    assign crc_err_o    = crc_q;
    assign resp_ready_o = (state_q == S_WAIT_RESP);
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_neosd_card_cmd.sv
// Bench for neosd_card_cmd: host-side SD_CLK/CMD driver, line monitor and frame-level reference model.
module tb_neosd_card_cmd;
    localparam int NCR = 2;

    logic         clk = 1'b0, rstn_i = 1'b0, sd_clk_i = 1'b1, sd_cmd_i = 1'b1;
    logic         sd_cmd_o, sd_cmd_oe, cmd_valid_o, resp_ready_o, busy_o, frm_err_o, crc_err_o;
    logic [5:0]   cmd_idx_o;
    logic [31:0]  cmd_arg_o;
    logic         resp_valid_i = 1'b0;
    logic [1:0]   resp_type_i = 2'd0;
    logic [127:0] resp_dat_i = '0;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    neosd_card_cmd #(.NCR_CYCLES(NCR)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .sd_clk_i(sd_clk_i), .sd_cmd_i(sd_cmd_i),
        .sd_cmd_o(sd_cmd_o), .sd_cmd_oe(sd_cmd_oe), .cmd_valid_o(cmd_valid_o),
        .cmd_idx_o(cmd_idx_o), .cmd_arg_o(cmd_arg_o), .resp_valid_i(resp_valid_i),
        .resp_type_i(resp_type_i), .resp_dat_i(resp_dat_i), .resp_ready_o(resp_ready_o),
        .busy_o(busy_o), .frm_err_o(frm_err_o), .crc_err_o(crc_err_o)
    );

    // Reference model state
    logic [5:0]  exp_idx = '0;
    logic [31:0] exp_arg = '0;
    bit chk_hold = 1'b0, exp_quiet = 1'b1;

    // Monitor state
    bit mon_prev = 1'b0, armed = 1'b0, started = 1'b0, done = 1'b0;
    int n_valid = 0, n_frm = 0, n_crc = 0, nfalls = 0, ncr_seen = 0, nbits = 0;
    logic [135:0] acc = '0;

    task automatic chk(input string name, input logic [135:0] got, input logic [135:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // CRC7 as polynomial division: remainder of M(x)*x^7 by x^7+x^3+1; message in the low n bits.
    function automatic logic [6:0] m_crc7(input logic [135:0] msg, input int n);
        logic [142:0] r;
        r = {msg, 7'b0};
        for (int i = n + 6; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] pre;
        pre = {2'b01, idx, arg};
        return {pre, m_crc7(136'(pre), 40), 1'b1};
    endfunction

    function automatic logic [135:0] m_resp(input logic [1:0] rt, input logic [127:0] d);
        logic [39:0] pre;
        pre = {2'b00, d[37:0]};
        case (rt)
            2'd0:    return 136'({pre, m_crc7(136'(pre), 40), 1'b1});
            2'd1:    return 136'({pre, 7'h7F, 1'b1});
            default: return {8'h3F, d[127:8], m_crc7(136'(d[127:8]), 120), 1'b1};
        endcase
    endfunction

    // Per-cycle compare process plus line capture at every SD_CLK rise while the card drives.
    always @(negedge clk) begin
        if (sd_clk_i && !mon_prev) begin
            if (armed && sd_cmd_oe) begin
                acc = {acc[134:0], sd_cmd_o};
                nbits++;
            end else if (armed && nbits > 0) begin
                done = 1'b1;
            end
        end
        if (armed && !started) begin
            if (sd_cmd_oe) begin
                started  = 1'b1;
                ncr_seen = nfalls;
            end else if (!sd_clk_i && mon_prev) begin
                nfalls++;
            end
        end
        mon_prev = sd_clk_i;
        if (cmd_valid_o) n_valid++;
        if (frm_err_o)   n_frm++;
        if (crc_err_o)   n_crc++;
        if (rstn_i) begin
            if (chk_hold)  chk("idx_arg_hold", 136'({cmd_idx_o, cmd_arg_o}), 136'({exp_idx, exp_arg}));
            if (exp_quiet) chk("oe_quiet", 136'(sd_cmd_oe), 136'(0));
`ifndef NEOSD_CARD_CRC_CHECK_EN
            chk("crc_err_tied", 136'(crc_err_o), 136'(0));
`endif
        end
    end

    // One SD_CLK period; CMD changes with the falling edge, card samples on the rise.
    task automatic sd_period(input logic b);
        sd_clk_i = 1'b0;
        sd_cmd_i = b;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 sd_clk_i = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
    endtask

    task automatic reset_check();
        chk_hold = 1'b0;
        rstn_i   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_oe", 136'(sd_cmd_oe), 136'(0));
        chk("rst_cmd_o", 136'(sd_cmd_o), 136'(1));
        chk("rst_busy", 136'(busy_o), 136'(0));
        chk("rst_ready", 136'(resp_ready_o), 136'(0));
        chk("rst_pulses", 136'({cmd_valid_o, frm_err_o, crc_err_o}), 136'(0));
        chk("rst_idx_arg", 136'({cmd_idx_o, cmd_arg_o}), 136'(0));
        @(posedge clk);
        #1 rstn_i = 1'b1;
        exp_idx = '0; exp_arg = '0; armed = 1'b0; exp_quiet = 1'b1; chk_hold = 1'b1;
    endtask

    // Send one command frame, answer it with a response of type rt, check everything observable.
    // rst_at > 0 forces a reset once that many response bits have gone out.
    task automatic do_cmd(input logic [47:0] f, input logic [1:0] rt, input logic [127:0] d,
                          input int rst_at);
        bit exp_v, exp_f, exp_c;
        int elen;
        exp_f = !(f[46] && f[0]);
        exp_c = 1'b0;
`ifdef NEOSD_CARD_CRC_CHECK_EN
        exp_c = !exp_f && (m_crc7(136'(f[47:8]), 40) != f[7:1]);
`endif
        exp_v = !exp_f && !exp_c;
        chk("busy_before", 136'(busy_o), 136'(0));
        chk_hold = 1'b0;
        n_valid = 0; n_frm = 0; n_crc = 0;
        for (int i = 47; i >= 0; i--) sd_period(f[i]);
        repeat (3) sd_period(1'b1);
        chk("valid_cnt", 136'(n_valid), 136'(exp_v));
        chk("frm_cnt", 136'(n_frm), 136'(exp_f));
        chk("crc_cnt", 136'(n_crc), 136'(exp_c));
        if (exp_v) begin
            exp_idx = f[45:40];
            exp_arg = f[39:8];
        end
        chk_hold = 1'b1;
        if (!exp_v) return;
        chk("ready", 136'(resp_ready_o), 136'(1));
        chk("busy_wait", 136'(busy_o), 136'(1));
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        started = 1'b0; done = 1'b0; nfalls = 0; ncr_seen = 0; nbits = 0; acc = '0;
        resp_valid_i = 1'b1; resp_type_i = rt; resp_dat_i = d;
        if (rt != 2'd3) exp_quiet = 1'b0;
        @(posedge clk);
        #1 resp_valid_i = 1'b0;
        if (rt == 2'd3) begin
            repeat (2) @(posedge clk);
            #1;
            chk("busy_after_t3", 136'(busy_o), 136'(0));
            return;
        end
        armed = 1'b1;
        elen  = (rt == 2'd2) ? 136 : 48;
        for (int k = 0; k < 400 && !done; k++) begin
            if (rst_at > 0 && nbits >= rst_at) break;
            sd_period(1'b1);
        end
        if (rst_at > 0) begin
            chk("reached_rst_bit", 136'(nbits >= rst_at), 136'(1));
            reset_check();
            return;
        end
        armed = 1'b0;
        chk("resp_done", 136'(done), 136'(1));
        chk("ncr_falls", 136'(ncr_seen), 136'(NCR + 1));
        chk("resp_len", 136'(nbits), 136'(elen));
        chk("resp_bits", acc, m_resp(rt, d));
        exp_quiet = 1'b1;
        chk("busy_after", 136'(busy_o), 136'(0));
    endtask

    initial begin
        logic [47:0]  f;
        logic [127:0] d;
        int kind, pos;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_oe", 136'(sd_cmd_oe), 136'(0));
        chk("init_cmd_o", 136'(sd_cmd_o), 136'(1));
        chk("init_busy_ready", 136'({busy_o, resp_ready_o}), 136'(0));
        chk("init_idx_arg", 136'({cmd_idx_o, cmd_arg_o}), 136'(0));
        @(posedge clk);
        #1 rstn_i = 1'b1;
        chk_hold = 1'b1;
        @(posedge clk);
        #1;

        // Model pins against known SD frames
        chk("model_crc_cmd0", 136'(m_crc7(136'(40'h4000000000), 40)), 136'(7'h4A));
        chk("model_crc_cmd8", 136'(m_crc7(136'(40'h48000001AA), 40)), 136'(7'h43));
        chk("model_cmd0_frame", 136'(mk_cmd(6'd0, 32'h0)), 136'(48'h400000000095));

        do_cmd(48'h400000000095, 2'd3, '0, 0);
        chk("cmd0_idx_arg", 136'({cmd_idx_o, cmd_arg_o}), 136'({6'd0, 32'h0}));
        do_cmd(48'h48000001AA87, 2'd3, '0, 0);
        chk("cmd8_idx_arg", 136'({cmd_idx_o, cmd_arg_o}), 136'({6'd8, 32'h000001AA}));
        chk("cmd8_oe", 136'(sd_cmd_oe), 136'(0));

        d = {90'b0, 6'h3F, 32'h80FF8000};
        do_cmd(mk_cmd(6'd41, 32'h40FF8000), 2'd1, d, 0);
        chk("acmd41_line", acc, 136'(48'h3F80FF8000FF));
        chk("acmd41_idx", 136'(cmd_idx_o), 136'(6'd41));

        do_cmd(48'h400000000097, 2'd3, '0, 0);
        do_cmd(48'h000000000095, 2'd3, '0, 0);

        d = {$urandom, $urandom, $urandom, $urandom};
        do_cmd(mk_cmd(6'd2, 32'h0), 2'd2, d, 20);
        do_cmd(48'h400000000095, 2'd3, '0, 0);
        chk("post_rst_cmd0", 136'({cmd_idx_o, cmd_arg_o}), 136'(0));

        for (int t = 0; t < 16; t++) begin
            f    = mk_cmd(6'($urandom_range(0, 63)), 32'($urandom));
            kind = $urandom_range(0, 5);
            pos  = $urandom_range(1, 7);
            if (kind == 0)      f[46]  = 1'b0;
            else if (kind == 1) f[0]   = 1'b0;
            else if (kind == 2) f[pos] = ~f[pos];
            d = {$urandom, $urandom, $urandom, $urandom};
            do_cmd(f, 2'($urandom_range(0, 3)), d, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/neosd_card_cmd.md
NEOSD_CARD_CMD -- requirements
Module: neosd_card_cmd

Interface
REQ-001 SHALL have parameter NCR_CYCLES, default 2, meaning: idle SD_CLK periods between response accept and response start bit (legal 2..64).
REQ-002 SHALL have port clk_i  in  1  system clock; one clock, all logic on rising edge.
REQ-003 SHALL have port rstn_i  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port sd_clk_i  in  1  SD_CLK from host, synchronous to clk_i, each level held >=1 clk_i cycle.
REQ-005 SHALL have ports sd_cmd_i in 1, sd_cmd_o out 1, sd_cmd_oe out 1: CMD line input, drive value, drive enable.
REQ-006 SHALL have outputs cmd_valid_o 1 (one-cycle pulse), cmd_idx_o 6, cmd_arg_o 32: received command; idx/arg held until next valid command.
REQ-007 SHALL have inputs resp_valid_i 1, resp_type_i 2, resp_dat_i 128 and output resp_ready_o 1: response request handshake.
REQ-008 SHALL have outputs busy_o 1, frm_err_o 1 (pulse), crc_err_o 1 (pulse).

Function
REQ-009 SHALL detect SD_CLK rise as sd_clk_i=1 with previous-cycle sample 0, fall as the inverse.
REQ-010 SHALL sample sd_cmd_i only in rise cycles; SHALL change sd_cmd_o/sd_cmd_oe only in the clk_i cycle after a fall cycle.
REQ-011 SHALL implement states IDLE, RX, CHECK, WAIT_RESP, NCR, TX, RELEASE.
REQ-012 IDLE: sampled 0 on a rise -> RX with bit counter 1; busy_o=0 only in IDLE.
REQ-013 RX: shift 48 bits MSB first total; after 48th bit -> CHECK.
REQ-014 CHECK (one clk_i cycle): bit46 must be 1 and bit0 must be 1, else frm_err_o pulse, -> IDLE; if valid, cmd_idx_o=bits[45:40], cmd_arg_o=bits[39:8], cmd_valid_o pulse, -> WAIT_RESP.
REQ-015 WAIT_RESP: resp_ready_o=1; transfer when resp_valid_i&resp_ready_o; resp_type 3 -> IDLE, else latch type/data, -> NCR.
REQ-016 Command start bits arriving outside IDLE SHALL be ignored.
REQ-017 NCR: sd_cmd_oe=0 for NCR_CYCLES SD_CLK falls, then at next fall -> TX driving start bit.
REQ-018 Type 0 (short): 48 bits = 0,0,resp_dat_i[37:32],resp_dat_i[31:0],CRC7,1.
REQ-019 Type 1 (R3): as type 0 but CRC field 7'b1111111.
REQ-020 Type 2 (long R2): 136 bits = 8'b00111111,resp_dat_i[127:8],CRC7 over those 120 bits,1.
REQ-021 CRC7 SHALL use polynomial x^7+x^3+1, init 0, over all bits preceding the CRC field (type 0), MSB first.
REQ-022 TX: one bit per SD_CLK fall, sd_cmd_oe=1; after end bit held one full period -> RELEASE.
REQ-023 RELEASE: at next fall sd_cmd_oe=0, sd_cmd_o=1, -> IDLE.
REQ-024 Bit counter SHALL be 8 bits, no wrap in any state.

Reset
REQ-025 rstn_i=0 at a clock edge SHALL force state IDLE, sd_cmd_oe=0, sd_cmd_o=1, resp_ready_o=0, all pulses 0, cmd_idx_o=0, cmd_arg_o=0, busy_o=0, including mid-RX/TX.
REQ-026 Edge-detect register SHALL reset to 0.

Configuration
REQ-027 With NEOSD_CARD_CRC_CHECK_EN defined, CHECK SHALL compute CRC7 over bits[47:8]; mismatch with bits[7:1] -> crc_err_o pulse, no cmd_valid_o, -> IDLE (frame errors take priority).
REQ-028 Without NEOSD_CARD_CRC_CHECK_EN, received CRC SHALL be ignored and crc_err_o tied 0; response CRC generation unaffected.

Verification
REQ-029 CMD0: frame 0x400000000095 -> cmd_valid_o pulse, idx 0, arg 0x00000000, no error pulses.
REQ-030 CMD8 0x48000001AA87, resp_type 3 -> cmd_valid_o idx 8 arg 0x000001AA, sd_cmd_oe stays 0, returns IDLE.
REQ-031 ACMD41 frame, resp_type 1, resp_dat_i[37:0]={6'h3F,32'h80FF8000} -> after 2 idle SD_CLK periods line carries 0x3F80FF8000FF MSB first, then oe=0.
REQ-032 CMD0 with CRC byte 0x97 -> with macro crc_err_o pulse, no cmd_valid_o; without macro cmd_valid_o idx 0.
REQ-033 Frame 0x000000000095 (transmission bit 0) -> frm_err_o pulse, no cmd_valid_o.
REQ-034 rstn_i low during TX bit 20 of type-2 response -> next cycle sd_cmd_oe=0, IDLE; next CMD0 decoded normally.
